exc_commit: RTL and testbench
=============================

# exc_commit

Writeback-stage exception commit unit for the LoongArch pipeline. It sits between the WB stage and the CSR file. It does four things: picks the highest-priority exception or interrupt on the retiring instruction, emits the one-cycle exception and ERTN strobes that the CSR file consumes, drains outstanding memory transactions, and then issues a single front-end redirect. It also owns the outstanding-memory-request counter used for the drain.

## Interface
Parameters:
- OUTST_W, 4, width of the outstanding-request counter; max in-flight = 2^OUTST_W-1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ws_valid  in  1  WB holds a valid instruction this cycle
- ws_pc  in  32  PC of WB instruction
- ws_vaddr  in  32  faulting data address from EX/MEM
- ws_exc  in  5  flags: [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE
- ws_ertn  in  1  WB instruction is ERTN
- csr_crmd_ie  in  1  global interrupt enable
- csr_estat_is  in  13  pending interrupt bits
- csr_ecfg_lie  in  13  local interrupt enables
- csr_eentry  in  32  exception entry address
- csr_era  in  32  exception return address
- mem_req_fire  in  1  data-bus request accepted
- mem_resp_fire  in  1  data-bus response returned
- ws_allowin  out  1  WB may accept a new instruction
- wb_ex  out  1  exception commit strobe to CSR file
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  32  PC of excepting instruction
- wb_vaddr  out  32  bad virtual address
- ertn_flush  out  1  ERTN commit strobe to CSR file
- flush_all  out  1  squash IF..MEM
- mem_req_block  out  1  counter full; upstream must not issue
- redirect_valid  out  1  one-cycle redirect strobe
- redirect_pc  out  32  redirect target

## Operation
- The FSM has three states: IDLE, DRAIN, REDIRECT. It resets to IDLE.
- **Interrupt sampling:** `int_pend` is registered every cycle as `csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie)`.
- **Commit condition:** in IDLE, `commit = ws_valid & (int_pend | |ws_exc | ws_ertn)`.
- **Priority and codes** (ecode/esubcode; ERTN is taken only when no exception applies):
  - INT: 0x0/0
  - ADEF: 0x8/1
  - INE: 0xD/0
  - SYS: 0xB/0
  - BRK: 0xC/0
  - ALE: 0x9/0
  - ERTN: lowest priority.
- **Outputs on commit:**
  - Exception: `wb_ex=1`, `wb_pc=ws_pc`.
  - `wb_vaddr = ws_pc` for ADEF, `ws_vaddr` for ALE, 0 otherwise.
  - ERTN without exception: `ertn_flush=1`.
  - Target register captures `csr_eentry` (exception) or `csr_era` (ERTN).
  - FSM moves to DRAIN.
- **DRAIN:**
  - `flush_all=1`.
  - Leaves to REDIRECT when the next-cycle count is 0.
- **REDIRECT:**
  - `redirect_valid=1`, `redirect_pc=target`, `flush_all=1`.
  - Returns to IDLE after one cycle.
- **Counter:** +1 on `mem_req_fire`, -1 on `mem_resp_fire`, unchanged when both or neither assert. `mem_req_block = (count == 2^OUTST_W-1)`.
- **`ws_allowin`:** 1 only in IDLE when no commit occurs.

## Timing
- **Reset values:** every output is 0, count = 0, target = 0.
- **Strobes:** `wb_ex`, `wb_ecode`, `wb_esubcode`, `wb_pc`, `wb_vaddr` and `ertn_flush` are combinational in the commit cycle and last exactly one cycle. The CSR file updates on the following edge.
- **Redirect latency:**
  - Minimum 2 cycles after commit (commit, DRAIN with count 0, REDIRECT).
  - Extends by one cycle for each cycle the count stays nonzero.
- **`int_pend` timing:** it is one cycle behind the CSR state. An interrupt raised in cycle N can attach to an instruction no earlier than cycle N+1.
- **DRAIN/REDIRECT:** no commit is evaluated, and `ws_valid`/`ws_exc` are ignored.
- **Counter boundaries:**
  - `mem_resp_fire` at count 0 leaves the count at 0 (no underflow). A bench assertion flags it.
  - `mem_req_fire` at max saturates. A bench assertion flags it.
- **DRAIN exit with a request in flight:** a `mem_req_fire` landing during DRAIN still increments the count and delays the exit.
- **Reset mid-drain:** returns to IDLE at once, with no redirect.

## Configuration
- `EXC_COMMIT_INT_EN`:
  - Defined: interrupt sampling and INT priority are active.
  - Undefined: `int_pend` is tied to 0, the three `csr_*` interrupt inputs are unused, and INT is never produced.

## Structure
- **Shared package `exc_pkg`:**
  - ECODE_INT/ADE/ALE/SYS/BRK/INE constants.
  - ESUBCODE_ADEF.
  - `ws_exc` bit indices.
  - FSM state enum.
- **Sub-module:** `outst_cnt` (saturating up/down counter, parameter OUTST_W), exposing `count_is_zero_next` and `full`.

## Test plan
- **SYS commit:** `ws_valid=1`, `ws_exc=5'b00100`, `ws_pc=0x1c000100`, `csr_eentry=0x1c008000`, count 0.
  - `wb_ex=1`, `ecode=0xB`, `wb_pc=0x1c000100` in cycle 0.
  - `redirect_valid=1`, `redirect_pc=0x1c008000` in cycle 2.
- **Priority:** `ws_exc=5'b10001` (ADEF+ALE), `ws_pc=0x1c000003`.
  - `ecode=0x8`, `esubcode=1`, `wb_vaddr=0x1c000003`.
- **ERTN:** `ws_ertn=1`, `csr_era=0x1c000104`.
  - `ertn_flush=1`, `wb_ex=0`.
  - `redirect_pc=0x1c000104` after 2 cycles.
- **Drain:** count=2, commit ALE (`ws_vaddr=0x00000802`), responses in cycles 3 and 5.
  - `flush_all` stays high.
  - `redirect_valid` fires in cycle 6.
- **Interrupt:** `csr_crmd_ie=1`, `estat_is[11]=1`, `ecfg_lie[11]=1`, then `ws_valid=1` with no exception flags.
  - `ecode=0x0`.
  - With `EXC_COMMIT_INT_EN` undefined: no commit.
- **Reset in DRAIN:** assert `reset` while count=1.
  - All outputs 0 immediately.
  - No `redirect_valid` after release.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared encodings for the writeback exception commit unit: ecodes, ws_exc bit positions, FSM states.
// The interrupt path in exc_commit is built only when EXC_COMMIT_INT_EN is defined.
package exc_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd1;

  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_ALE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REDIRECT
  } state_e;

endpackage

// File: rtl/outst_cnt.sv
// Saturating up/down count of in-flight data-bus requests; flags full and "count is zero after this edge".
// Latency: count updates on the clock edge; count_is_zero_next is combinational from this cycle's fire pulses.
module outst_cnt #(
  parameter int OUTST_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic count_is_zero_next,
  output logic full
);

  localparam logic [OUTST_W-1:0] CNT_MAX = '1;
  localparam logic [OUTST_W-1:0] CNT_ONE = OUTST_W'(1);

  logic [OUTST_W-1:0] count_q;
  logic [OUTST_W-1:0] count_d;

  // Saturates at both ends rather than wrapping, so a stray pulse cannot corrupt the drain.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_is_zero_next = (count_d == '0);
  assign full               = (count_q == CNT_MAX);

endmodule

// File: rtl/exc_commit.sv
// WB exception commit: prioritise exception/interrupt/ERTN, strobe the CSR file, drain memory, then redirect.
// EXC_COMMIT_INT_EN enables interrupt sampling; without it interrupts are never taken.
module exc_commit
  import exc_pkg::*;
#(
  parameter int OUTST_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic [4:0]  ws_exc,
  input  logic        ws_ertn,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        mem_req_fire,
  input  logic        mem_resp_fire,
  output logic        ws_allowin,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush_all,
  output logic        mem_req_block,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        int_pend;
  logic        exc_any;
  logic        commit;
  logic        cnt_zero_next;
  logic        cnt_full;

`ifdef EXC_COMMIT_INT_EN
  logic int_pend_q;

  // Sampled one cycle behind the CSRs to keep the CSR read off the commit path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_pend_q <= 1'b0;
    end else begin
      int_pend_q <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    end
  end
  assign int_pend = int_pend_q;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{csr_crmd_ie, csr_estat_is, csr_ecfg_lie};
  assign int_pend          = 1'b0;
`endif

  outst_cnt #(
    .OUTST_W(OUTST_W)
  ) u_outst_cnt (
    .clk               (clk),
    .reset             (reset),
    .inc_i             (mem_req_fire),
    .dec_i             (mem_resp_fire),
    .count_is_zero_next(cnt_zero_next),
    .full              (cnt_full)
  );

  assign exc_any       = int_pend | (|ws_exc);
  assign commit        = !reset && (state_q == ST_IDLE) && ws_valid && (exc_any || ws_ertn);
  assign mem_req_block = cnt_full;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    ws_allowin     = 1'b0;
    wb_ex          = 1'b0;
    wb_ecode       = 6'h00;
    wb_esubcode    = 9'h000;
    wb_pc          = 32'h0;
    wb_vaddr       = 32'h0;
    ertn_flush     = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          ws_allowin = !commit;
          if (commit) begin
            state_d = ST_DRAIN;
            if (exc_any) begin
              wb_ex    = 1'b1;
              wb_pc    = ws_pc;
              target_d = csr_eentry;
              if (int_pend) begin
                wb_ecode = ECODE_INT;
              end else if (ws_exc[EXC_ADEF]) begin
                wb_ecode    = ECODE_ADE;
                wb_esubcode = ESUBCODE_ADEF;
                wb_vaddr    = ws_pc;
              end else if (ws_exc[EXC_INE]) begin
                wb_ecode = ECODE_INE;
              end else if (ws_exc[EXC_SYS]) begin
                wb_ecode = ECODE_SYS;
              end else if (ws_exc[EXC_BRK]) begin
                wb_ecode = ECODE_BRK;
              end else begin
                wb_ecode = ECODE_ALE;
                wb_vaddr = ws_vaddr;
              end
            end else begin
              ertn_flush = 1'b1;
              target_d   = csr_era;
            end
          end
        end
        ST_DRAIN: begin
          flush_all = 1'b1;
          // Looks at the post-edge count so a request landing now keeps us draining.
          if (cnt_zero_next) begin
            state_d = ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          flush_all      = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Bench for exc_commit: decode table, directed drain/interrupt/saturation/reset sequences, then random traffic
// checked every cycle against a behavioural model.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ertn, csr_crmd_ie, mem_req_fire, mem_resp_fire;
  logic [31:0] ws_pc, ws_vaddr, csr_eentry, csr_era;
  logic [4:0]  ws_exc;
  logic [12:0] csr_estat_is, csr_ecfg_lie;
  logic        ws_allowin, wb_ex, ertn_flush, flush_all, mem_req_block, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, redirect_pc;

  always #5 clk = ~clk;

  exc_commit #(.OUTST_W(4)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
    .ws_exc(ws_exc), .ws_ertn(ws_ertn), .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is),
    .csr_ecfg_lie(csr_ecfg_lie), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .mem_req_fire(mem_req_fire), .mem_resp_fire(mem_resp_fire), .ws_allowin(ws_allowin),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .flush_all(flush_all),
    .mem_req_block(mem_req_block), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_underflow = 0;
  int n_saturate = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = accepting, 1 = waiting for memory to go quiet, 2 = redirecting.
  int          m_phase;
  int          m_cnt;
  logic [31:0] m_target;
  logic        m_intp;
  int          prio_code[6] = '{0, 8, 13, 11, 12, 9};

  logic        e_allowin, e_ex, e_ef, e_flush, e_block, e_redir, e_commit;
  logic [5:0]  e_ecode;
  logic [8:0]  e_sub;
  logic [31:0] e_pc, e_vaddr, e_rpc;

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_target = 32'h0; m_intp = 1'b0;
  endtask

  task automatic compute_exp();
    logic cause[6];
    logic any_exc;
    int   sel;
    {e_allowin, e_ex, e_ef, e_flush, e_block, e_redir, e_commit} = '0;
    e_ecode = '0; e_sub = '0; e_pc = '0; e_vaddr = '0; e_rpc = '0;
    if (reset) return;
    cause[0] = m_intp;
    for (int i = 0; i < 5; i++) cause[i+1] = ws_exc[i];
    any_exc = 1'b0;
    sel = -1;
    for (int i = 0; i < 6; i++) begin
      if (cause[i] && sel < 0) sel = i;
      any_exc |= cause[i];
    end
    e_block = (m_cnt == 15);
    if (m_phase == 0) begin
      e_commit  = ws_valid && (any_exc || ws_ertn);
      e_allowin = !e_commit;
      if (e_commit && any_exc) begin
        e_ex    = 1'b1;
        e_ecode = 6'(prio_code[sel]);
        e_sub   = (sel == 1) ? 9'd1 : 9'd0;
        e_pc    = ws_pc;
        e_vaddr = (sel == 1) ? ws_pc : (sel == 5) ? ws_vaddr : 32'h0;
      end else if (e_commit) begin
        e_ef = 1'b1;
      end
    end else begin
      e_flush = 1'b1;
      if (m_phase == 2) begin
        e_redir = 1'b1;
        e_rpc   = m_target;
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    if (mem_req_fire && !mem_resp_fire) begin
      if (m_cnt == 15) n_saturate++;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end else if (mem_resp_fire && !mem_req_fire) begin
      if (m_cnt == 0) n_underflow++;
      m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    end
    case (m_phase)
      0: if (e_commit) begin
           m_phase  = 1;
           m_target = e_ex ? csr_eentry : csr_era;
         end
      1: if (m_cnt == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
`ifdef EXC_COMMIT_INT_EN
    m_intp = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'h0);
`else
    m_intp = 1'b0;
`endif
  endtask

  task automatic check_all();
    compute_exp();
    chk("ws_allowin", 32'(ws_allowin), 32'(e_allowin));
    chk("wb_ex", 32'(wb_ex), 32'(e_ex));
    chk("wb_ecode", 32'(wb_ecode), 32'(e_ecode));
    chk("wb_esubcode", 32'(wb_esubcode), 32'(e_sub));
    chk("wb_pc", wb_pc, e_pc);
    chk("wb_vaddr", wb_vaddr, e_vaddr);
    chk("ertn_flush", 32'(ertn_flush), 32'(e_ef));
    chk("flush_all", 32'(flush_all), 32'(e_flush));
    chk("mem_req_block", 32'(mem_req_block), 32'(e_block));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  // Inputs are driven at the falling edge; one cycle = check, rising edge, model step, next falling edge.
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    compute_exp();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ws_valid = 1'b0; ws_exc = 5'h0; ws_ertn = 1'b0;
    mem_req_fire = 1'b0; mem_resp_fire = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  exc;
    logic        ertn;
    logic [31:0] pc;
    logic [31:0] va;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  sub;
    logic [31:0] wva;
    logic        ef;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    ws_pc = 32'h0; ws_vaddr = 32'h0;
    csr_crmd_ie = 1'b0; csr_estat_is = '0; csr_ecfg_lie = '0;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000104;
    model_reset();

    tbl[0] = '{5'b00100, 1'b0, 32'h1c000100, 32'h0,        1'b1, 6'hB, 9'd0, 32'h0,        1'b0, 32'h1c008000};
    tbl[1] = '{5'b10001, 1'b0, 32'h1c000003, 32'h00000802, 1'b1, 6'h8, 9'd1, 32'h1c000003, 1'b0, 32'h1c008000};
    tbl[2] = '{5'b00000, 1'b1, 32'h1c000200, 32'h0,        1'b0, 6'h0, 9'd0, 32'h0,        1'b1, 32'h1c000104};
    tbl[3] = '{5'b10000, 1'b0, 32'h1c000300, 32'h00000802, 1'b1, 6'h9, 9'd0, 32'h00000802, 1'b0, 32'h1c008000};
    tbl[4] = '{5'b00110, 1'b0, 32'h1c000400, 32'h0,        1'b1, 6'hD, 9'd0, 32'h0,        1'b0, 32'h1c008000};
    tbl[5] = '{5'b11000, 1'b0, 32'h1c000500, 32'h00001234, 1'b1, 6'hC, 9'd0, 32'h0,        1'b0, 32'h1c008000};
    tbl[6] = '{5'b01000, 1'b1, 32'h1c000600, 32'h0,        1'b1, 6'hC, 9'd0, 32'h0,        1'b0, 32'h1c008000};

    // Reset state, including a would-be commit held during reset.
    @(negedge clk);
    ws_valid = 1'b1; ws_exc = 5'b00100;
    cyc();
    idle_inputs();
    cyc();
    reset = 1'b0;
    cyc();

    // Decode table: commit cycle strobes, then redirect two cycles later.
    foreach (tbl[i]) begin
      ws_valid = 1'b1; ws_exc = tbl[i].exc; ws_ertn = tbl[i].ertn;
      ws_pc = tbl[i].pc; ws_vaddr = tbl[i].va;
      #1;
      chk($sformatf("tbl%0d wb_ex", i), 32'(wb_ex), 32'(tbl[i].ex));
      chk($sformatf("tbl%0d ecode", i), 32'(wb_ecode), 32'(tbl[i].ecode));
      chk($sformatf("tbl%0d esubcode", i), 32'(wb_esubcode), 32'(tbl[i].sub));
      chk($sformatf("tbl%0d wb_pc", i), wb_pc, tbl[i].ex ? tbl[i].pc : 32'h0);
      chk($sformatf("tbl%0d wb_vaddr", i), wb_vaddr, tbl[i].wva);
      chk($sformatf("tbl%0d ertn_flush", i), 32'(ertn_flush), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d allowin", i), 32'(ws_allowin), 32'h0);
      cyc();
      idle_inputs();
      cyc();
      #1;
      chk($sformatf("tbl%0d redirect_valid", i), 32'(redirect_valid), 32'h1);
      chk($sformatf("tbl%0d redirect_pc", i), redirect_pc, tbl[i].rpc);
      cyc();
    end

    // Drain: two requests outstanding, ALE commit, responses in cycles 3 and 5, redirect in cycle 6.
    mem_req_fire = 1'b1;
    cyc(); cyc();
    mem_req_fire = 1'b0;
    ws_valid = 1'b1; ws_exc = 5'b10000; ws_pc = 32'h1c000700; ws_vaddr = 32'h00000802;
    cyc();
    idle_inputs();
    for (int c = 1; c <= 5; c++) begin
      mem_resp_fire = (c == 3 || c == 5);
      #1;
      chk($sformatf("drain c%0d flush_all", c), 32'(flush_all), 32'h1);
      chk($sformatf("drain c%0d redirect_valid", c), 32'(redirect_valid), 32'h0);
      cyc();
    end
    mem_resp_fire = 1'b0;
    #1;
    chk("drain c6 redirect_valid", 32'(redirect_valid), 32'h1);
    chk("drain c6 redirect_pc", redirect_pc, 32'h1c008000);
    cyc();

    // Interrupt raised one cycle, then a plain instruction arrives.
    csr_crmd_ie = 1'b1; csr_estat_is = 13'h0800; csr_ecfg_lie = 13'h0800;
    cyc();
    csr_crmd_ie = 1'b0; csr_estat_is = '0; csr_ecfg_lie = '0;
    ws_valid = 1'b1; ws_pc = 32'h1c000800;
    #1;
`ifdef EXC_COMMIT_INT_EN
    chk("int wb_ex", 32'(wb_ex), 32'h1);
    chk("int ecode", 32'(wb_ecode), 32'h0);
`else
    chk("int wb_ex", 32'(wb_ex), 32'h0);
    chk("int allowin", 32'(ws_allowin), 32'h1);
`endif
    cyc();
    idle_inputs();
    repeat (4) cyc();

    // Counter saturation and underflow, then a commit must redirect in minimum time.
    mem_req_fire = 1'b1;
    repeat (17) cyc();
    #1;
    chk("sat block", 32'(mem_req_block), 32'h1);
    mem_req_fire = 1'b0; mem_resp_fire = 1'b1;
    cyc();
    #1;
    chk("sat block after resp", 32'(mem_req_block), 32'h0);
    repeat (16) cyc();
    mem_resp_fire = 1'b0;
    ws_valid = 1'b1; ws_exc = 5'b01000; ws_pc = 32'h1c000900;
    cyc();
    idle_inputs();
    cyc();
    #1;
    chk("post-underflow redirect", 32'(redirect_valid), 32'h1);
    cyc();

    // Reset while draining with one request outstanding.
    mem_req_fire = 1'b1;
    cyc();
    mem_req_fire = 1'b0;
    ws_valid = 1'b1; ws_exc = 5'b00100; ws_pc = 32'h1c000a00;
    cyc();
    idle_inputs();
    cyc();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst flush_all", 32'(flush_all), 32'h0);
    chk("rst allowin", 32'(ws_allowin), 32'h0);
    chk("rst redirect_valid", 32'(redirect_valid), 32'h0);
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("post-rst c%0d redirect_valid", c), 32'(redirect_valid), 32'h0);
      cyc();
    end

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      ws_valid      = ($urandom_range(0, 9) < 4);
      ws_exc        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
      ws_ertn       = ($urandom_range(0, 9) == 0);
      ws_pc         = $urandom;
      ws_vaddr      = $urandom;
      csr_eentry    = $urandom;
      csr_era       = $urandom;
      mem_req_fire  = ($urandom_range(0, 1) == 1);
      mem_resp_fire = ($urandom_range(0, 99) < 45);
      csr_crmd_ie   = ($urandom_range(0, 1) == 1);
      csr_estat_is  = ($urandom_range(0, 9) == 0) ? 13'(1 << $urandom_range(0, 12)) : 13'h0;
      csr_ecfg_lie  = 13'($urandom);
      cyc();
    end

    $display("Counter boundary stimulus seen: underflow %0d, saturate %0d", n_underflow, n_saturate);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
